// File: rtl/unum4_pack_arb.sv
// unum4_pack_arb: round-robin front end sharing one pipelined unum4 pack unit
// between N_REQ requesters. A tag pipeline follows each in-flight operation so
// the result returns on a broadcast bus labelled with its requester id. A
// RUN/DRAIN/FLUSHED state machine lets software quiesce the unit.
// Optional statistics counters: define UNUM4_PACK_ARB_STATS_EN.
module unum4_pack_arb #(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int DATA_W    = 32,
  parameter int EXP_MAX_W = 16,
  parameter int MAN_W     = 32,
  parameter int PACK_LAT  = 3,
  parameter int OVER_ADV  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*EXP_MAX_W-1:0] req_exp,
  input  logic [N_REQ*MAN_W-1:0]     req_mant,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rsp_valid,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_over,
  input  logic                       flush,
  output logic                       flush_done,
  output logic                       busy,
  output logic                       err,
  output logic                       pk_start,
  output logic [EXP_MAX_W-1:0]       pk_exp,
  output logic [MAN_W-1:0]           pk_mant,
  input  logic                       pk_done,
  input  logic [DATA_W-1:0]          pk_o,
  input  logic                       pk_over,
  output logic [31:0]                ops_cnt,
  output logic [31:0]                over_cnt
);

  localparam int MASK_W = $clog2(PACK_LAT + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FLUSHED} state_t;

  state_t              state_q, state_d;
  logic                arb_en;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     gnt_id;
  logic                gnt_found;
  logic [PACK_LAT-1:0] tag_v_q;
  logic [ID_W-1:0]     tag_id_q [PACK_LAT];
  logic [MASK_W-1:0]   mask_q;
  logic                masked;
  logic                over_d;
  logic                err_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  end

  // Next state and arbitration enable; flush seen in RUN blocks that cycle's grant
  always_comb begin
    state_d    = state_q;
    arb_en     = 1'b0;
    flush_done = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        arb_en = !flush && !rst;
        if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!busy) state_d = ST_FLUSHED;
      end
      ST_FLUSHED: begin
        flush_done = 1'b1;
        if (!flush) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Round-robin grant: indices above ptr first, then wrap to 0..ptr
  always_comb begin
    req_ready = '0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    pk_exp    = '0;
    pk_mant   = '0;
    if (arb_en) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!gnt_found && req_valid[i] && (i > 32'(ptr_q))) begin
          gnt_found    = 1'b1;
          gnt_id       = ID_W'(i);
          req_ready[i] = 1'b1;
          pk_exp       = req_exp[i*EXP_MAX_W +: EXP_MAX_W];
          pk_mant      = req_mant[i*MAN_W +: MAN_W];
        end
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!gnt_found && req_valid[i] && (i <= 32'(ptr_q))) begin
          gnt_found    = 1'b1;
          gnt_id       = ID_W'(i);
          req_ready[i] = 1'b1;
          pk_exp       = req_exp[i*EXP_MAX_W +: EXP_MAX_W];
          pk_mant      = req_mant[i*MAN_W +: MAN_W];
        end
      end
    end
  end

  assign pk_start = |req_ready;

  // Round-robin pointer follows the last grant
  always_ff @(posedge clk) begin
    if (rst)           ptr_q <= ID_W'(N_REQ - 1);
    else if (pk_start) ptr_q <= gnt_id;
  end

  // Tag pipeline: {valid, id} travels alongside each pack operation
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v_q <= '0;
      for (int unsigned i = 0; i < PACK_LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_v_q[0]  <= pk_start;
      tag_id_q[0] <= gnt_id;
      for (int unsigned i = 1; i < PACK_LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  // Post-reset mask: pk_done pulses from pre-reset operations are ignored
  always_ff @(posedge clk) begin
    if (rst)                 mask_q <= MASK_W'(PACK_LAT);
    else if (mask_q != '0)   mask_q <= mask_q - MASK_W'(1);
  end

  assign masked = (mask_q != '0);

  // pk_over leads pk_done by OVER_ADV cycles; realign it with the result
  generate
    if (OVER_ADV == 0) begin : g_over_pass
      assign over_d = pk_over;
    end else begin : g_over_dly
      logic [OVER_ADV-1:0] over_sr;
      // Over delay line
      always_ff @(posedge clk) begin
        if (rst) begin
          over_sr <= '0;
        end else begin
          over_sr[0] <= pk_over;
          for (int unsigned i = 1; i < OVER_ADV; i++) over_sr[i] <= over_sr[i-1];
        end
      end
      assign over_d = over_sr[OVER_ADV-1];
    end
  endgenerate

  // Sticky error on any done/tag disagreement outside the mask window
  always_ff @(posedge clk) begin
    if (rst)                                            err_q <= 1'b0;
    else if (!masked && (pk_done != tag_v_q[PACK_LAT-1])) err_q <= 1'b1;
  end

  assign err       = err_q;
  assign busy      = |tag_v_q;
  assign rsp_valid = pk_done & tag_v_q[PACK_LAT-1] & ~masked;
  assign rsp_id    = tag_id_q[PACK_LAT-1];
  assign rsp_data  = pk_o;
  assign rsp_over  = over_d;

`ifdef UNUM4_PACK_ARB_STATS_EN
  logic [31:0] ops_q, over_q;

  // Operation and overflow statistics, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_q  <= '0;
      over_q <= '0;
    end else begin
      if (pk_start)             ops_q  <= ops_q + 32'd1;
      if (rsp_valid && rsp_over) over_q <= over_q + 32'd1;
    end
  end

  assign ops_cnt  = ops_q;
  assign over_cnt = over_q;
`else
  assign ops_cnt  = '0;
  assign over_cnt = '0;
`endif

endmodule

// File: doc/unum4_pack_arb.md
Name: unum4_pack_arb

Overview:
- Shares one pipelined unum4 pack unit between N_REQ requesters using round-robin arbitration.
- Issues at most one pack operation per cycle.
- Tracks in-flight operations with a tag pipeline, so each packed result returns on a broadcast response bus tagged with its requester id.
- Provides a flush/drain state machine so software can quiesce the unit before reconfiguration.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester id width; must satisfy 2^ID_W >= N_REQ.
- DATA_W, 32, packed word width.
- EXP_MAX_W, 16, exponent width.
- MAN_W, 32, mantissa width including extra rounding bits (MAN_MAX_W+EXTRA of the pack unit).
- PACK_LAT, 3, cycles from pk_start sampled to pk_done asserted.
- OVER_ADV, 1, cycles by which pk_over leads pk_done (0..PACK_LAT-1).

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- req_valid, input, N_REQ, per-requester request.
- req_exp, input, N_REQ*EXP_MAX_W, flattened exponents; requester i at [i*EXP_MAX_W +: EXP_MAX_W].
- req_mant, input, N_REQ*MAN_W, flattened mantissas.
- req_ready, output, N_REQ, one-hot grant; handshake completes when req_valid[i] & req_ready[i].
- rsp_valid, output, 1, result valid (no backpressure).
- rsp_id, output, ID_W, requester id of the result.
- rsp_data, output, DATA_W, packed word.
- rsp_over, output, 1, rounding overflow of this result.
- flush, input, 1, request to stop issuing and drain.
- flush_done, output, 1, high while drained in FLUSHED.
- busy, output, 1, at least one operation in flight.
- err, output, 1, sticky tag/done mismatch.
- pk_start, output, 1, to pack unit start.
- pk_exp, output, EXP_MAX_W, to pack unit exp.
- pk_mant, output, MAN_W, to pack unit mant.
- pk_done, input, 1, from pack unit.
- pk_o, input, DATA_W, from pack unit.
- pk_over, input, 1, from pack unit.
- ops_cnt, output, 32, statistics (see Optional Feature).
- over_cnt, output, 32, statistics (see Optional Feature).

Behaviour:
- Reset (synchronous, rst high at posedge) sets:
  - all outputs, tag pipeline and over delay line to 0;
  - rr pointer to N_REQ-1, so requester 0 has first priority;
  - state to RUN.
- Reset mid-operation discards in-flight tags. pk_done pulses arriving in the PACK_LAT cycles after reset are ignored: a post-reset mask counter suppresses both err and rsp_valid.
- Arbitration (combinational, RUN only): grant the first i with req_valid[i], scanning circularly from ptr+1.
  - req_ready is one-hot or zero.
  - pk_start = |req_ready.
  - pk_exp/pk_mant are muxed from the granted requester in the same cycle.
  - On grant, ptr <= granted index at the next edge.
  - Requests not granted hold; no starvation; a requester granted every cycle is allowed only when it is the sole requester.
- Tag pipeline: PACK_LAT-stage shift register of {valid, id}.
  - Stage 0 loads {pk_start, granted id} each cycle.
  - Output stage T is compared with pk_done.
- Response (combinational from pack outputs, no added latency):
  - rsp_valid = pk_done & T.valid.
  - rsp_id = T.id.
  - rsp_data = pk_o.
  - rsp_over = pk_over delayed OVER_ADV cycles (OVER_ADV=0: pass-through).
- err: set when pk_done != T.valid, outside the post-reset mask. Cleared only by rst.
- busy = OR of tag valid bits.
- State machine:
  - RUN: arbitrate. flush=1 -> DRAIN; no grant in the cycle flush is first seen.
  - DRAIN: no grants; when busy==0 -> FLUSHED.
  - FLUSHED: flush_done=1, no grants; flush=0 -> RUN, with arbitration resuming the next cycle.
- Simultaneous flush and request in RUN: flush wins; the request stays pending.
- flush deasserted during DRAIN: finish the drain, pass through FLUSHED for one cycle, then RUN.

Optional Feature:
- Macro: UNUM4_PACK_ARB_STATS_EN.
- When defined:
  - ops_cnt increments on each pk_start.
  - over_cnt increments on each rsp_valid & rsp_over.
  - Both are 32-bit, wrap at 2^32, cleared by rst.
- When undefined: counters not built; ops_cnt and over_cnt tied to 0.

Test Plan:
- Single request from requester 2 (exp=0x0003, mant=0x40000000), pack model PACK_LAT=3 -> req_ready=0b0100 at cycle 0; rsp_valid with rsp_id=2 at cycle 3; rsp_data equals model output.
- All four req_valid held high for 8 cycles after reset -> grant order 0,1,2,3,0,1,2,3; responses return in the same id order 3 cycles later, one per cycle.
- Model asserts pk_over one cycle before pk_done for the request from requester 1 -> rsp_over=1 only on rsp_id=1; with STATS_EN, over_cnt=1 and ops_cnt equals the number of grants.
- Issue 3 back-to-back operations, then flush=1 -> no further grants; busy falls 3 cycles after the last grant; flush_done=1 the following cycle; flush=0 -> next grant one cycle later, starting after the last granted index.
- rst pulsed one cycle after two grants -> outputs 0; model's trailing pk_done pulses produce no rsp_valid and no err; a new request after reset starts at requester 0.
- Model injects a spurious pk_done with an empty tag stage -> err=1 and stays 1 until rst; rsp_valid stays 0 that cycle.
